// File: rtl/ysyx_040066_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
// Holds the channel FSM encoding, bus field widths and a wrap helper.
package ysyx_040066_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam int LEN_W  = 3;
  localparam int MASK_W = 8;

  // Index following g in a ring of n masters.
  function automatic int wrap_inc(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/ysyx_040066_rr_pick.sv
// Request picker: round-robin from ptr, or fixed lowest-index-first.
// Ports: req in, ptr in, rr_en in; gnt (one-hot), idx, any out.
module ysyx_040066_rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          rr_en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int   base;
    int   j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    base  = rr_en ? int'(ptr) : 0;
    if (base >= N) base = 0;
    for (int i = 0; i < N; i++) begin
      j = base + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/ysyx_040066_mem_arbiter.sv
// N-master to 1-slave memory arbiter with independent read/write channels,
// round-robin or fixed priority, and a per-channel watchdog.
// Ports: m_rd_* / m_wr_* master side, s_rd_* / s_wr_* slave side,
// rd_gnt / wr_gnt one-hot current grants.
module ysyx_040066_mem_arbiter
  import ysyx_040066_arb_pkg::*;
#(
  parameter int N_MST  = 2,
  parameter int AW     = 64,
  parameter int DW     = 64,
  parameter int LINE_W = 512,
  parameter int RR     = 1,
  parameter int TO_CYC = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MST-1:0]        m_rd_req,
  input  logic [N_MST-1:0]        m_rd_burst,
  input  logic [LEN_W*N_MST-1:0]  m_rd_len,
  input  logic [AW*N_MST-1:0]     m_rd_addr,
  output logic [N_MST-1:0]        m_rd_ready,
  output logic [N_MST-1:0]        m_rd_last,
  output logic [N_MST-1:0]        m_rd_err,
  output logic [DW-1:0]           m_rd_data,
  input  logic [N_MST-1:0]        m_wr_req,
  input  logic [N_MST-1:0]        m_wr_burst,
  input  logic [LEN_W*N_MST-1:0]  m_wr_len,
  input  logic [MASK_W*N_MST-1:0] m_wr_mask,
  input  logic [AW*N_MST-1:0]     m_wr_addr,
  input  logic [LINE_W*N_MST-1:0] m_wr_data,
  output logic [N_MST-1:0]        m_wr_ready,
  output logic [N_MST-1:0]        m_wr_err,
  output logic                    s_rd_req,
  output logic                    s_rd_burst,
  output logic [LEN_W-1:0]        s_rd_len,
  output logic [AW-1:0]           s_rd_addr,
  input  logic                    s_rd_ready,
  input  logic                    s_rd_last,
  input  logic                    s_rd_err,
  input  logic [DW-1:0]           s_rd_data,
  output logic                    s_wr_req,
  output logic                    s_wr_burst,
  output logic [LEN_W-1:0]        s_wr_len,
  output logic [MASK_W-1:0]       s_wr_mask,
  output logic [AW-1:0]           s_wr_addr,
  output logic [LINE_W-1:0]       s_wr_data,
  input  logic                    s_wr_ready,
  input  logic                    s_wr_err,
  output logic [N_MST-1:0]        rd_gnt,
  output logic [N_MST-1:0]        wr_gnt
);

  localparam int IW = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam bit TO_EN = (TO_CYC > 0);
  localparam int CW = TO_EN ? $clog2(TO_CYC + 1) : 1;
  // Error fires in the BUSY cycle where the counter shows TO_CYC-1,
  // i.e. on the TO_CYC-th silent cycle.
  localparam logic [CW-1:0] LIM = TO_EN ? CW'(TO_CYC - 1) : '0;

  // ---------------- read channel ----------------
  arb_state_t       rd_st;
  logic [IW-1:0]    rd_g;
  logic [IW-1:0]    rd_ptr;
  logic [CW-1:0]    rd_cnt;
  logic [N_MST-1:0] rd_pick_gnt;
  logic [IW-1:0]    rd_pick_idx;
  logic             rd_any;
  logic             rd_busy;
  logic             rd_to;
  logic             rd_fail;
  logic             rd_ok;
  logic             rd_done;

  ysyx_040066_rr_pick #(.N(N_MST), .IW(IW)) u_rd_pick (
    .req   (m_rd_req),
    .ptr   (rd_ptr),
    .rr_en (RR != 0),
    .gnt   (rd_pick_gnt),
    .idx   (rd_pick_idx),
    .any   (rd_any)
  );

  assign rd_busy = (rd_st == ST_BUSY);
  assign rd_to   = TO_EN && rd_busy && (rd_cnt == LIM)
                   && !s_rd_ready && !s_rd_err;
  assign rd_fail = rd_busy && (s_rd_err || rd_to);
  // Error wins over a coincident ready.
  assign rd_ok   = rd_busy && s_rd_ready && !s_rd_err;
  assign rd_done = rd_fail || (rd_ok && s_rd_last);

  assign m_rd_ready = rd_ok ? rd_gnt : '0;
  assign m_rd_last  = (rd_ok && s_rd_last) ? rd_gnt : '0;
  assign m_rd_err   = rd_fail ? rd_gnt : '0;
  assign m_rd_data  = s_rd_data;

  assign s_rd_req   = rd_busy;
  assign s_rd_burst = rd_busy && m_rd_burst[rd_g];
  assign s_rd_len   = rd_busy ? m_rd_len[int'(rd_g)*LEN_W +: LEN_W] : '0;
  assign s_rd_addr  = rd_busy ? m_rd_addr[int'(rd_g)*AW +: AW] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_st  <= ST_IDLE;
      rd_g   <= '0;
      rd_gnt <= '0;
      rd_ptr <= '0;
      rd_cnt <= '0;
    end else begin
      case (rd_st)
        ST_IDLE: begin
          rd_cnt <= '0;
          if (rd_any) begin
            rd_st  <= ST_BUSY;
            rd_g   <= rd_pick_idx;
            rd_gnt <= rd_pick_gnt;
          end
        end
        ST_BUSY: begin
          if (rd_done) begin
            rd_st  <= ST_IDLE;
            rd_gnt <= '0;
            rd_cnt <= '0;
            if (RR != 0) rd_ptr <= IW'(wrap_inc(int'(rd_g), N_MST));
          end else if (s_rd_ready) begin
            // Each delivered beat restarts the watchdog.
            rd_cnt <= '0;
          end else if (TO_EN) begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        default: rd_st <= ST_IDLE;
      endcase
    end
  end

  // ---------------- write channel ----------------
  arb_state_t       wr_st;
  logic [IW-1:0]    wr_g;
  logic [IW-1:0]    wr_ptr;
  logic [CW-1:0]    wr_cnt;
  logic [N_MST-1:0] wr_pick_gnt;
  logic [IW-1:0]    wr_pick_idx;
  logic             wr_any;
  logic             wr_busy;
  logic             wr_to;
  logic             wr_fail;
  logic             wr_ok;
  logic             wr_done;

  ysyx_040066_rr_pick #(.N(N_MST), .IW(IW)) u_wr_pick (
    .req   (m_wr_req),
    .ptr   (wr_ptr),
    .rr_en (RR != 0),
    .gnt   (wr_pick_gnt),
    .idx   (wr_pick_idx),
    .any   (wr_any)
  );

  assign wr_busy = (wr_st == ST_BUSY);
  assign wr_to   = TO_EN && wr_busy && (wr_cnt == LIM)
                   && !s_wr_ready && !s_wr_err;
  assign wr_fail = wr_busy && (s_wr_err || wr_to);
  assign wr_ok   = wr_busy && s_wr_ready && !s_wr_err;
  assign wr_done = wr_fail || wr_ok;

  assign m_wr_ready = wr_ok ? wr_gnt : '0;
  assign m_wr_err   = wr_fail ? wr_gnt : '0;

  assign s_wr_req   = wr_busy;
  assign s_wr_burst = wr_busy && m_wr_burst[wr_g];
  assign s_wr_len   = wr_busy ? m_wr_len[int'(wr_g)*LEN_W +: LEN_W] : '0;
  assign s_wr_mask  = wr_busy ? m_wr_mask[int'(wr_g)*MASK_W +: MASK_W] : '0;
  assign s_wr_addr  = wr_busy ? m_wr_addr[int'(wr_g)*AW +: AW] : '0;
  assign s_wr_data  = wr_busy ? m_wr_data[int'(wr_g)*LINE_W +: LINE_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_st  <= ST_IDLE;
      wr_g   <= '0;
      wr_gnt <= '0;
      wr_ptr <= '0;
      wr_cnt <= '0;
    end else begin
      case (wr_st)
        ST_IDLE: begin
          wr_cnt <= '0;
          if (wr_any) begin
            wr_st  <= ST_BUSY;
            wr_g   <= wr_pick_idx;
            wr_gnt <= wr_pick_gnt;
          end
        end
        ST_BUSY: begin
          if (wr_done) begin
            wr_st  <= ST_IDLE;
            wr_gnt <= '0;
            wr_cnt <= '0;
            if (RR != 0) wr_ptr <= IW'(wrap_inc(int'(wr_g), N_MST));
          end else if (TO_EN) begin
            wr_cnt <= wr_cnt + 1'b1;
          end
        end
        default: wr_st <= ST_IDLE;
      endcase
    end
  end

endmodule
